// File: rtl/trap_controller_if.sv
// Trap controller interface: exception/interrupt inputs, CSR update strobes and
// the fetch redirect handshake. The master side is the trap controller itself.
interface trap_controller_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_EXC_SRC = 3
);
  logic [NUM_EXC_SRC*6-1:0]    exc_i;
  logic [NUM_EXC_SRC*XLEN-1:0] exc_pc_i;
  logic [NUM_EXC_SRC*XLEN-1:0] exc_tval_i;
  logic [XLEN-1:0]             int_pc_i;
  logic                        int_pc_valid_i;
  logic                        mstatus_mie_i;
  logic [XLEN-1:0]             mie_i;
  logic [XLEN-1:0]             mip_i;
  logic [XLEN-1:0]             mtvec_i;
  logic [XLEN-1:0]             mepc_i;
  logic                        mret_i;
  logic                        redirect_ready_i;
  logic                        flush_o;
  logic                        csr_trap_we_o;
  logic                        csr_mret_o;
  logic [XLEN-1:0]             mepc_o;
  logic [XLEN-1:0]             mcause_o;
  logic [XLEN-1:0]             mtval_o;
  logic                        redirect_valid_o;
  logic [XLEN-1:0]             redirect_pc_o;
  logic                        busy_o;

  modport master (
    input  exc_i, exc_pc_i, exc_tval_i, int_pc_i, int_pc_valid_i, mstatus_mie_i,
           mie_i, mip_i, mtvec_i, mepc_i, mret_i, redirect_ready_i,
    output flush_o, csr_trap_we_o, csr_mret_o, mepc_o, mcause_o, mtval_o,
           redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    output exc_i, exc_pc_i, exc_tval_i, int_pc_i, int_pc_valid_i, mstatus_mie_i,
           mie_i, mip_i, mtvec_i, mepc_i, mret_i, redirect_ready_i,
    input  flush_o, csr_trap_we_o, csr_mret_o, mepc_o, mcause_o, mtval_o,
           redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET in IDLE,
// strobes the CSR file and pipeline flush for one cycle, then holds a fetch
// redirect until it is accepted.
module trap_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_EXC_SRC = 3
) (
  input logic               clk,
  input logic               rst_n,
  trap_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [4:0]      CODE_MSI = 5'd3;
  localparam logic [4:0]      CODE_MTI = 5'd7;
  localparam logic [4:0]      CODE_MEI = 5'd11;
  localparam logic [4:0]      CODE_COF = 5'd13;
  localparam logic [XLEN-1:0] INT_MASK = XLEN'(32'h0000_2888);
  localparam logic [XLEN-1:0] ALIGN    = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic            flush_q, flush_d;
  logic            csr_trap_we_q, csr_trap_we_d;
  logic            csr_mret_q, csr_mret_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            is_mret_q, is_mret_d;

  logic            exc_hit;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] pend;
  logic            int_hit;
  logic [4:0]      int_code;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] int_target;

  // Select the oldest raised exception and the highest-priority enabled interrupt
  always_comb begin
    exc_hit  = 1'b0;
    exc_code = '0;
    exc_pc   = '0;
    exc_tval = '0;
    for (int unsigned i = 0; i < NUM_EXC_SRC; i++) begin
      if (!exc_hit && bus.exc_i[i*6+5]) begin
        exc_hit  = 1'b1;
        exc_code = bus.exc_i[i*6 +: 5];
        exc_pc   = bus.exc_pc_i[i*XLEN +: XLEN];
        exc_tval = bus.exc_tval_i[i*XLEN +: XLEN];
      end
    end

    pend    = bus.mie_i & bus.mip_i;
    int_hit = bus.mstatus_mie_i && bus.int_pc_valid_i && ((pend & INT_MASK) != '0);
    if (pend[11])      int_code = CODE_MEI;
    else if (pend[3])  int_code = CODE_MSI;
    else if (pend[7])  int_code = CODE_MTI;
    else               int_code = CODE_COF;

    // Vectored mode only applies to interrupts; reserved modes behave as direct
    vec_base   = bus.mtvec_i & ALIGN;
    int_target = vec_base;
    if (bus.mtvec_i[1:0] == 2'b01)
      int_target = vec_base + ({{(XLEN-5){1'b0}}, int_code} << 2);
  end

  // Next-state and registered-output computation for the trap sequence
  always_comb begin
    state_d          = state_q;
    flush_d          = 1'b0;
    csr_trap_we_d    = 1'b0;
    csr_mret_d       = 1'b0;
    mepc_d           = '0;
    mcause_d         = '0;
    mtval_d          = '0;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    target_d         = target_q;
    is_mret_d        = is_mret_q;

    unique case (state_q)
      IDLE: begin
        if (exc_hit) begin
          state_d       = COMMIT;
          flush_d       = 1'b1;
          csr_trap_we_d = 1'b1;
          mepc_d        = exc_pc & ALIGN;
          mcause_d      = {1'b0, {(XLEN-6){1'b0}}, exc_code};
          mtval_d       = exc_tval;
          target_d      = vec_base;
          is_mret_d     = 1'b0;
        end else if (int_hit) begin
          state_d       = COMMIT;
          flush_d       = 1'b1;
          csr_trap_we_d = 1'b1;
          mepc_d        = bus.int_pc_i & ALIGN;
          mcause_d      = {1'b1, {(XLEN-6){1'b0}}, int_code};
          mtval_d       = '0;
          target_d      = int_target;
          is_mret_d     = 1'b0;
        end else if (bus.mret_i) begin
          state_d    = COMMIT;
          flush_d    = 1'b1;
          csr_mret_d = 1'b1;
          target_d   = '0;
          is_mret_d  = 1'b1;
        end
      end
      COMMIT: begin
        // MRET target is taken from mepc as seen during the commit cycle
        state_d          = REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = is_mret_q ? bus.mepc_i : target_q;
      end
      REDIRECT: begin
        if (bus.redirect_ready_i) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
          redirect_pc_d    = '0;
        end
      end
      default: begin
        state_d          = IDLE;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any sequence immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      csr_trap_we_q    <= 1'b0;
      csr_mret_q       <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
      target_q         <= '0;
      is_mret_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_q          <= flush_d;
      csr_trap_we_q    <= csr_trap_we_d;
      csr_mret_q       <= csr_mret_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
      target_q         <= target_d;
      is_mret_q        <= is_mret_d;
    end
  end

  assign bus.flush_o          = flush_q;
  assign bus.csr_trap_we_o    = csr_trap_we_q;
  assign bus.csr_mret_o       = csr_mret_q;
  assign bus.mepc_o           = mepc_q;
  assign bus.mcause_o         = mcause_q;
  assign bus.mtval_o          = mtval_q;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios followed by random
// events compared against a behavioural trap model.
module tb_trap_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  trap_controller_if #(.XLEN(32), .NUM_EXC_SRC(3)) bus ();

  trap_controller #(.XLEN(32), .NUM_EXC_SRC(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state owned by the bench
  bit          s_raise [3];
  logic [4:0]  s_code  [3];
  logic [31:0] s_pc    [3];
  logic [31:0] s_tval  [3];
  logic [31:0] s_int_pc;
  bit          s_int_valid;
  bit          s_gie;
  logic [31:0] s_mie;
  logic [31:0] s_mip;
  logic [31:0] s_mtvec;
  logic [31:0] s_mepc;
  bit          s_mret;
  bit          s_ready;

  typedef struct {
    bit          take;
    bit          is_mret;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] target;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      bus.exc_i[i*6 +: 6]       = {s_raise[i], s_code[i]};
      bus.exc_pc_i[i*32 +: 32]  = s_pc[i];
      bus.exc_tval_i[i*32 +: 32] = s_tval[i];
    end
    bus.int_pc_i         = s_int_pc;
    bus.int_pc_valid_i   = s_int_valid;
    bus.mstatus_mie_i    = s_gie;
    bus.mie_i            = s_mie;
    bus.mip_i            = s_mip;
    bus.mtvec_i          = s_mtvec;
    bus.mepc_i           = s_mepc;
    bus.mret_i           = s_mret;
    bus.redirect_ready_i = s_ready;
  endtask

  task automatic clear_events();
    for (int i = 0; i < 3; i++) s_raise[i] = 1'b0;
    s_mret      = 1'b0;
    s_mip       = '0;
    s_int_valid = 1'b0;
  endtask

  // Behavioural model: what trap (if any) the current inputs should produce
  function automatic exp_t predict();
    exp_t        e;
    int          prio [4];
    logic [31:0] pend;
    logic [31:0] base;
    prio = '{11, 3, 7, 13};
    e = '{take: 1'b0, is_mret: 1'b0, mcause: '0, mepc: '0, mtval: '0, target: '0};
    base = s_mtvec & 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      if (s_raise[i]) begin
        e.take   = 1'b1;
        e.mcause = 32'(s_code[i]);
        e.mepc   = s_pc[i] & 32'hFFFF_FFFC;
        e.mtval  = s_tval[i];
        e.target = base;
        return e;
      end
    end
    pend = s_mie & s_mip;
    if (s_gie && s_int_valid) begin
      for (int k = 0; k < 4; k++) begin
        if (pend[prio[k]]) begin
          e.take   = 1'b1;
          e.mcause = 32'h8000_0000 + 32'(prio[k]);
          e.mepc   = s_int_pc & 32'hFFFF_FFFC;
          e.mtval  = '0;
          e.target = (s_mtvec[1:0] == 2'd1) ? base + 32'(4 * prio[k]) : base;
          return e;
        end
      end
    end
    if (s_mret) begin
      e.take    = 1'b1;
      e.is_mret = 1'b1;
    end
    return e;
  endfunction

  // Present the current stimulus at a negedge in IDLE and check the commit cycle
  task automatic commit_phase(output exp_t e);
    apply();
    chk("idle_busy", bus.busy_o, 1'b0);
    e = predict();
    @(negedge clk);
    if (!e.take) begin
      chk("notrap_busy", bus.busy_o, 1'b0);
      chk("notrap_flush", bus.flush_o, 1'b0);
      chk("notrap_we", bus.csr_trap_we_o, 1'b0);
      clear_events();
      apply();
      return;
    end
    chk("commit_busy", bus.busy_o, 1'b1);
    chk("commit_flush", bus.flush_o, 1'b1);
    chk("commit_we", bus.csr_trap_we_o, e.is_mret ? 1'b0 : 1'b1);
    chk("commit_mret", bus.csr_mret_o, e.is_mret ? 1'b1 : 1'b0);
    chk("commit_rvalid", bus.redirect_valid_o, 1'b0);
    if (!e.is_mret) begin
      chk("mcause", bus.mcause_o, e.mcause);
      chk("mepc", bus.mepc_o, e.mepc);
      chk("mtval", bus.mtval_o, e.mtval);
    end else begin
      // mepc may change after the MRET is seen; the commit-cycle value is the target
      s_mepc   = $urandom;
      e.target = s_mepc;
    end
    clear_events();
    s_ready = 1'b0;
    apply();
  endtask

  task automatic run_event(input int hold, input bit noise);
    exp_t e;
    commit_phase(e);
    if (!e.take) return;
    if (noise) begin
      s_raise[$urandom_range(0, 2)] = 1'b1;
      s_mret      = 1'b1;
      s_gie       = 1'b1;
      s_int_valid = 1'b1;
      s_mie       = 32'h0000_2888;
      s_mip       = 32'h0000_0800;
      apply();
    end
    @(negedge clk);
    chk("redir_valid", bus.redirect_valid_o, 1'b1);
    chk("redir_pc", bus.redirect_pc_o, e.target);
    chk("redir_flush", bus.flush_o, 1'b0);
    chk("redir_we", bus.csr_trap_we_o, 1'b0);
    chk("redir_mret", bus.csr_mret_o, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.redirect_valid_o, 1'b1);
      chk("hold_pc", bus.redirect_pc_o, e.target);
      chk("hold_we", bus.csr_trap_we_o, 1'b0);
      chk("hold_flush", bus.flush_o, 1'b0);
    end
    clear_events();
    s_ready = 1'b1;
    apply();
    @(negedge clk);
    chk("done_busy", bus.busy_o, 1'b0);
    chk("done_valid", bus.redirect_valid_o, 1'b0);
    chk("done_we", bus.csr_trap_we_o, 1'b0);
    s_ready = 1'b0;
    apply();
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      s_raise[i] = 1'b0; s_code[i] = '0; s_pc[i] = '0; s_tval[i] = '0;
    end
    s_int_pc = '0; s_int_valid = 1'b0; s_gie = 1'b0; s_mie = '0; s_mip = '0;
    s_mtvec = '0; s_mepc = '0; s_mret = 1'b0; s_ready = 1'b0;
    apply();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_valid", bus.redirect_valid_o, 1'b0);
    chk("rst_flush", bus.flush_o, 1'b0);
    chk("rst_pc", bus.redirect_pc_o, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Illegal instruction from source 1
    s_raise[1] = 1'b1; s_code[1] = 5'd2; s_pc[1] = 32'h100; s_tval[1] = 32'hDEAD;
    s_mtvec = 32'h8000;
    commit_phase(e);
    chk("t2_mcause", bus.mcause_o, 32'h2);
    chk("t2_mepc", bus.mepc_o, 32'h100);
    chk("t2_mtval", bus.mtval_o, 32'hDEAD);
    @(negedge clk);
    chk("t2_pc", bus.redirect_pc_o, 32'h8000);

    // Reset asserted in the middle of REDIRECT
    #2 rst_n = 1'b0;
    #1;
    chk("t1_busy", bus.busy_o, 1'b0);
    chk("t1_valid", bus.redirect_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_quiet", {bus.busy_o, bus.redirect_valid_o, bus.flush_o,
                       bus.csr_trap_we_o, bus.csr_mret_o}, 5'b0);
    end

    // Sources 0 and 2 plus MEI: source 0 wins
    s_raise[0] = 1'b1; s_code[0] = 5'd5; s_pc[0] = 32'h400; s_tval[0] = 32'h1234;
    s_raise[2] = 1'b1; s_code[2] = 5'd3; s_pc[2] = 32'h408;
    s_gie = 1'b1; s_int_valid = 1'b1; s_mie = 32'h800; s_mip = 32'h800;
    commit_phase(e);
    chk("t3_mcause", bus.mcause_o, 32'h5);
    chk("t3_mepc", bus.mepc_o, 32'h400);
    s_ready = 1'b1; apply();
    repeat (2) @(negedge clk);
    s_ready = 1'b0; apply();

    // MTI + MSI in vectored mode; then globally disabled
    s_mtvec = 32'h8001; s_gie = 1'b1; s_int_valid = 1'b1; s_int_pc = 32'h3000;
    s_mie = 32'h88; s_mip = 32'h88;
    commit_phase(e);
    chk("t4_mcause", bus.mcause_o, 32'h8000_0003);
    @(negedge clk);
    chk("t4_pc", bus.redirect_pc_o, 32'h800C);
    s_ready = 1'b1; apply();
    @(negedge clk);
    s_ready = 1'b0;
    s_gie = 1'b0; s_int_valid = 1'b1; s_mie = 32'h88; s_mip = 32'h88;
    apply();
    @(negedge clk);
    chk("t4_off_busy", bus.busy_o, 1'b0);
    chk("t4_off_we", bus.csr_trap_we_o, 1'b0);
    clear_events(); apply();

    // MRET with a 4-cycle stall; then exceptions during REDIRECT are ignored
    s_mepc = 32'h2000; s_mret = 1'b1;
    run_event(4, 1'b0);
    s_raise[2] = 1'b1; s_code[2] = 5'd11; s_pc[2] = 32'h44; s_mtvec = 32'h9000;
    run_event(2, 1'b1);

    // Random events against the model
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        s_raise[i] = ($urandom_range(0, 5) == 0);
        s_code[i]  = 5'($urandom_range(0, 15));
        s_pc[i]    = $urandom;
        s_tval[i]  = $urandom;
      end
      s_int_pc    = $urandom;
      s_int_valid = $urandom_range(0, 1) != 0;
      s_gie       = $urandom_range(0, 1) != 0;
      s_mie       = $urandom & 32'h0000_2888;
      s_mip       = $urandom & 32'h0000_2888;
      s_mtvec     = $urandom;
      s_mepc      = $urandom;
      s_mret      = ($urandom_range(0, 3) == 0);
      run_event($urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
